pc_gen: RTL

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen_pkg.sv | 15 +
 rtl/pc_gen_ras.sv | 55 +++++
 rtl/pc_gen.sv | 67 ++++++
 3 files changed

// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared next-PC select encoding, FSM states and reset vector
package pc_gen_pkg;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  typedef enum logic [2:0] {
    SRC_SEQ    = 3'd0,
    SRC_BRANCH = 3'd1,
    SRC_TRAP   = 3'd2,
    SRC_MRET   = 3'd3,
    SRC_RET    = 3'd4
  } pc_src_e;
  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } pc_state_e;
endpackage

// File: rtl/pc_gen_ras.sv
// ras_stack: circular return-address stack, oldest entry overwritten when full
// ports: clk, reset (async, active-high), push/pop + push_data in, top/empty/full out
module ras_stack
  import pc_gen_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  logic [XLEN-1:0] mem_q [RAS_DEPTH];
  logic [XLEN-1:0] mem_d [RAS_DEPTH];
  logic [PW-1:0]   wr_q, wr_d, top_idx;
  logic [CW-1:0]   cnt_q, cnt_d;
  assign top_idx = wr_q - PW'(1);
  assign top     = mem_q[top_idx];
  assign empty   = cnt_q == '0;
  assign full    = cnt_q == CW'(RAS_DEPTH);
  // push+pop together replaces the top in place, leaving pointer and count alone
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (push && pop) begin
      mem_d[top_idx] = push_data;
    end else if (push) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + PW'(1);
      cnt_d       = full ? cnt_q : cnt_q + CW'(1);
    end else if (pop) begin
      wr_d  = top_idx;
      cnt_d = cnt_q - CW'(1);
    end
  end
  // entry data is not cleared by reset, only frozen while reset is held
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch PC register with sequential step, redirects and return-address stack
// ports: clk, reset (async, active-high), en_n stall, pc_src select, is_compressed, push_ras,
//        branch_addr/trap_vector/epc targets; pc, pc_next, pc_valid, ras_empty, ras_full, misaligned
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter bit              C_EXT        = 1'b1,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en_n,
  input  logic [2:0]      pc_src,
  input  logic            is_compressed,
  input  logic            push_ras,
  input  logic [XLEN-1:0] branch_addr,
  input  logic [XLEN-1:0] trap_vector,
  input  logic [XLEN-1:0] epc,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next,
  output logic            pc_valid,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            misaligned
);
  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, target, ras_top;
  logic            upd, redirect, ras_push, ras_pop;
  assign pc       = pc_q;
  assign pc_valid = state_q == ST_RUN;
  assign pc_next  = pc_q + ((C_EXT && is_compressed) ? XLEN'(2) : XLEN'(4));
  // codes 5-7 fall through to the sequential successor
  always_comb begin
    state_d    = ST_RUN;
    upd        = state_q == ST_RUN && !en_n;
    redirect   = pc_src inside {SRC_BRANCH, SRC_TRAP, SRC_MRET, SRC_RET};
    target     = pc_src == SRC_BRANCH ? branch_addr :
                 pc_src == SRC_TRAP   ? trap_vector :
                 pc_src == SRC_MRET   ? epc :
                 pc_src == SRC_RET    ? (ras_empty ? branch_addr : ras_top) : pc_next;
    ras_pop    = upd && pc_src == SRC_RET && !ras_empty;
    ras_push   = upd && push_ras && !(pc_src inside {SRC_TRAP, SRC_MRET});
    misaligned = !C_EXT && upd && redirect && target[1];
    pc_d       = upd ? {target[XLEN-1:1], 1'b0} : pc_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end
  ras_stack #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk      (clk),
    .reset    (reset),
    .push     (ras_push),
    .pop      (ras_pop),
    .push_data(pc_next),
    .top      (ras_top),
    .empty    (ras_empty),
    .full     (ras_full)
  );
endmodule
